// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the writeback producers, the register-file write port and the arbiter.
// The producer/register-file side uses the master modport and the arbiter uses the slave modport.
interface wb_port_arbiter_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
);
  // Requester A: in-order pipeline writeback, which has no backpressure.
  logic              a_valid;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;

  // Requester B: long-latency unit with a valid/ready handshake.
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;

  // Register-file write port and status outputs.
  logic                        rf_we;
  logic [ADDR_W-1:0]           rf_waddr;
  logic [DATA_W-1:0]           rf_wdata;
  logic                        grant_src;
  logic                        pipe_stall;
  logic [$clog2(FIFO_DEPTH):0] b_count;
  logic                        arb_err;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  b_ready, rf_we, rf_waddr, rf_wdata, grant_src, pipe_stall, b_count, arb_err
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output b_ready, rf_we, rf_waddr, rf_wdata, grant_src, pipe_stall, b_count, arb_err
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. Pipeline writeback (A) wins by default, and B is queued in a FIFO.
// When B has waited too long, a starvation counter stalls the pipeline so that B can drain.
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clock,
  input logic              reset,
  wb_port_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {NORMAL, STARVED} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem_q [FIFO_DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  state_e            state_q, state_d;
  logic              rf_we_q, grant_src_q, arb_err_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic              a_req, fifo_ne, grant_b, push;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    a_req    = bus.a_valid && (bus.a_rd != '0);
    fifo_ne  = (count_q != '0);
    grant_b  = !a_req && fifo_ne;
    push     = bus.b_valid && bus.b_ready && (bus.b_rd != '0);
    count_d  = count_q + CNT_W'(push) - CNT_W'(grant_b);
    starve_d = '0;
    if (fifo_ne && !grant_b)
      starve_d = (starve_q == STV_W'(STARVE_LIMIT)) ? starve_q : starve_q + STV_W'(1);
    state_d = state_q;
    if (starve_d == STV_W'(STARVE_LIMIT)) state_d = STARVED;
    else if (grant_b)                     state_d = NORMAL;
  end

  // NOTE: FIFO storage has no reset. The count and the pointers alone decide which entries are valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= '{rd: bus.b_rd, data: bus.b_data};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      grant_src_q <= 1'b0;
      arb_err_q   <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      state_q     <= NORMAL;
    end else begin
      rf_we_q <= a_req || grant_b;
      if (a_req) begin
        rf_waddr_q  <= bus.a_rd;
        rf_wdata_q  <= bus.a_data;
        grant_src_q <= 1'b0;
      end else if (grant_b) begin
        rf_waddr_q  <= head.rd;
        rf_wdata_q  <= head.data;
        grant_src_q <= 1'b1;
        rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
      end
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      count_q   <= count_d;
      starve_q  <= starve_d;
      state_q   <= state_d;
      arb_err_q <= arb_err_q || (bus.a_valid && (state_q == STARVED));
    end
  end

  // The reset term keeps B from being accepted while reset is asserted.
  assign bus.b_ready    = !reset && (count_q < CNT_W'(FIFO_DEPTH));
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.grant_src  = grant_src_q;
  assign bus.pipe_stall = (state_q == STARVED);
  assign bus.b_count    = count_q;
  assign bus.arb_err    = arb_err_q;
endmodule
